// File: rtl/id_stream.sv
// id_stream: decode / operand-fetch stage of the LA32R pipeline.
// It latches {pc, inst} from fetch through a valid/allowin handshake and reads
// the register file. RAW hazards are resolved by stalling, or by forwarding
// when that option is built in. Every branch and jump is resolved here, and the
// redirect goes back to fetch. The stage passes pc, inst, operands and
// destination info on to EX, where the full ALU and memory decode happens.
//
// Build option:
//   FORWARD_EN  Operands are taken from EX_fwd, then MEM_fwd, then WB_fwd, then
//               rf_rdata. The youngest matching stage wins. Only a load in EX
//               that matches a used source causes a stall. When this macro is
//               undefined, the forwarding inputs are ignored and any match in
//               EX, MEM or WB stalls.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   IF_to_ID_valid/IF_pc_in/IF_inst_in instruction offered by fetch
//   ID_allowin                         this stage can accept this cycle
//   EX_allowin                         EX can accept this cycle
//   ID_to_EX_valid, ID_pc_out, ID_inst_out, ID_rj_value, ID_rkd_value,
//   ID_dest, ID_gr_we                  outputs handed to EX
//   br_taken, br_target                redirect to fetch (single-cycle pulse)
//   rf_raddr1/2, rf_rdata1/2           register-file read ports
//   {EX,MEM,WB}_valid/_gr_we/_dest     downstream writer info for hazards
//   EX_is_load                         EX holds a load
//   {EX,MEM,WB}_fwd                    per-stage result data (forwarding only)
module id_stream #(
   parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IF_to_ID_valid,
   input  logic [31:0] IF_pc_in,
   input  logic [31:0] IF_inst_in,
   output logic        ID_allowin,
   input  logic        EX_allowin,
   output logic        ID_to_EX_valid,
   output logic [31:0] ID_pc_out,
   output logic [31:0] ID_inst_out,
   output logic [31:0] ID_rj_value,
   output logic [31:0] ID_rkd_value,
   output logic [4:0]  ID_dest,
   output logic        ID_gr_we,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        EX_valid,
   input  logic        MEM_valid,
   input  logic        WB_valid,
   input  logic        EX_gr_we,
   input  logic        MEM_gr_we,
   input  logic        WB_gr_we,
   input  logic [4:0]  EX_dest,
   input  logic [4:0]  MEM_dest,
   input  logic [4:0]  WB_dest,
   input  logic        EX_is_load,
   input  logic [31:0] EX_fwd,
   input  logic [31:0] MEM_fwd,
   input  logic [31:0] WB_fwd
);

   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready_go;

   logic [5:0]  op;
   logic        is_jirl, is_b, is_bl, is_cond, is_store;
   logic        use_rj, use_r2;
   logic [4:0]  dest;
   logic        cond_true;
   logic        ex_hit1, mem_hit1, wb_hit1;
   logic        ex_hit2, mem_hit2, wb_hit2;
   logic        stall;
   logic [31:0] rj_value, rkd_value;
   logic [31:0] off16, off26;

   assign op       = id_inst[31:26];
   assign is_jirl  = (op == 6'b010011);
   assign is_b     = (op == 6'b010100);
   assign is_bl    = (op == 6'b010101);
   assign is_cond  = (op >= 6'b010110) && (op <= 6'b011011);
   assign is_store = (id_inst[31:22] == 10'b0010100100) ||
                     (id_inst[31:22] == 10'b0010100101) ||
                     (id_inst[31:22] == 10'b0010100110);

   // Conditional branches and stores read rd as their second source.
   assign rf_raddr1 = id_inst[9:5];
   assign rf_raddr2 = (is_cond || is_store) ? id_inst[4:0] : id_inst[14:10];

   assign use_rj = !(is_b || is_bl ||
                     (id_inst[31:25] == 7'b0001010) ||
                     (id_inst[31:25] == 7'b0001110));
   assign use_r2 = (id_inst[31:22] == 10'd0) || is_cond || is_store;

   assign dest = is_bl ? 5'd1 : id_inst[4:0];

   // Register 0 is hard-wired, so it never matches a writer.
   assign ex_hit1  = EX_valid  && EX_gr_we  && (EX_dest  == rf_raddr1) && (rf_raddr1 != 5'd0);
   assign mem_hit1 = MEM_valid && MEM_gr_we && (MEM_dest == rf_raddr1) && (rf_raddr1 != 5'd0);
   assign wb_hit1  = WB_valid  && WB_gr_we  && (WB_dest  == rf_raddr1) && (rf_raddr1 != 5'd0);
   assign ex_hit2  = EX_valid  && EX_gr_we  && (EX_dest  == rf_raddr2) && (rf_raddr2 != 5'd0);
   assign mem_hit2 = MEM_valid && MEM_gr_we && (MEM_dest == rf_raddr2) && (rf_raddr2 != 5'd0);
   assign wb_hit2  = WB_valid  && WB_gr_we  && (WB_dest  == rf_raddr2) && (rf_raddr2 != 5'd0);

`ifdef FORWARD_EN
   assign rj_value  = ex_hit1  ? EX_fwd  :
                      mem_hit1 ? MEM_fwd :
                      wb_hit1  ? WB_fwd  : rf_rdata1;
   assign rkd_value = ex_hit2  ? EX_fwd  :
                      mem_hit2 ? MEM_fwd :
                      wb_hit2  ? WB_fwd  : rf_rdata2;
   // Load data does not exist until MEM, so only a load in EX must wait.
   assign stall = EX_is_load && ((use_rj && ex_hit1) || (use_r2 && ex_hit2));
`else
   logic unused_fwd;
   assign unused_fwd = ^{EX_fwd, MEM_fwd, WB_fwd, EX_is_load};
   assign rj_value  = rf_rdata1;
   assign rkd_value = rf_rdata2;
   assign stall = (use_rj && (ex_hit1 || mem_hit1 || wb_hit1)) ||
                  (use_r2 && (ex_hit2 || mem_hit2 || wb_hit2));
`endif

   assign id_ready_go = !stall;

   always_comb begin
      cond_true = 1'b0;
      case (op)
         6'b010110: cond_true = (rj_value == rkd_value);
         6'b010111: cond_true = (rj_value != rkd_value);
         6'b011000: cond_true = ($signed(rj_value) <  $signed(rkd_value));
         6'b011001: cond_true = ($signed(rj_value) >= $signed(rkd_value));
         6'b011010: cond_true = (rj_value <  rkd_value);
         6'b011011: cond_true = (rj_value >= rkd_value);
         default:   cond_true = 1'b0;
      endcase
   end

   assign off16 = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};
   assign off26 = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};

   always_comb begin
      br_target = id_pc + off16;
      if (is_jirl)
         br_target = rj_value + off16;
      else if (is_b || is_bl)
         br_target = id_pc + off26;
   end

   // Gated by EX_allowin so a held branch redirects only once, on the cycle
   // it actually leaves.
   assign br_taken = id_valid && id_ready_go && EX_allowin &&
                     (is_b || is_bl || is_jirl || (is_cond && cond_true));

   assign ID_allowin     = !id_valid || (id_ready_go && EX_allowin);
   assign ID_to_EX_valid = id_valid && id_ready_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid <= 1'b0;
         id_pc    <= RESET_PC;
         id_inst  <= 32'd0;
      end else begin
         if (ID_allowin)
            id_valid <= IF_to_ID_valid && !br_taken;   // drop the wrong-path slot
         if (IF_to_ID_valid && ID_allowin) begin
            id_pc   <= IF_pc_in;
            id_inst <= IF_inst_in;
         end
      end
   end

   assign ID_pc_out    = id_pc;
   assign ID_inst_out  = id_inst;
   assign ID_rj_value  = rj_value;
   assign ID_rkd_value = rkd_value;
   assign ID_dest      = dest;
   assign ID_gr_we     = !(is_b || is_cond || is_store || (dest == 5'd0));

endmodule

// File: tb/tb_id_stream.sv
module tb_id_stream;
   localparam logic [31:0] RESET_PC = 32'h1bfffffc;

   logic        clk = 1'b0;
   logic        reset;
   logic        IF_to_ID_valid;
   logic [31:0] IF_pc_in, IF_inst_in;
   logic        ID_allowin, EX_allowin, ID_to_EX_valid;
   logic [31:0] ID_pc_out, ID_inst_out, ID_rj_value, ID_rkd_value;
   logic [4:0]  ID_dest;
   logic        ID_gr_we, br_taken;
   logic [31:0] br_target;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        EX_valid, MEM_valid, WB_valid;
   logic        EX_gr_we, MEM_gr_we, WB_gr_we;
   logic [4:0]  EX_dest, MEM_dest, WB_dest;
   logic        EX_is_load;
   logic [31:0] EX_fwd, MEM_fwd, WB_fwd;

   logic [31:0] rf [32];
   int checks = 0;
   int failures = 0;

   // reference state of the stage
   logic        m_valid;
   logic [31:0] m_pc, m_inst;

   always #5 clk = ~clk;

   always_comb begin
      rf_rdata1 = rf[rf_raddr1];
      rf_rdata2 = rf[rf_raddr2];
   end

   id_stream #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .IF_to_ID_valid(IF_to_ID_valid), .IF_pc_in(IF_pc_in), .IF_inst_in(IF_inst_in),
      .ID_allowin(ID_allowin), .EX_allowin(EX_allowin), .ID_to_EX_valid(ID_to_EX_valid),
      .ID_pc_out(ID_pc_out), .ID_inst_out(ID_inst_out),
      .ID_rj_value(ID_rj_value), .ID_rkd_value(ID_rkd_value),
      .ID_dest(ID_dest), .ID_gr_we(ID_gr_we),
      .br_taken(br_taken), .br_target(br_target),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .EX_valid(EX_valid), .MEM_valid(MEM_valid), .WB_valid(WB_valid),
      .EX_gr_we(EX_gr_we), .MEM_gr_we(MEM_gr_we), .WB_gr_we(WB_gr_we),
      .EX_dest(EX_dest), .MEM_dest(MEM_dest), .WB_dest(WB_dest),
      .EX_is_load(EX_is_load),
      .EX_fwd(EX_fwd), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd)
   );

   typedef struct {
      logic        allowin, to_ex, taken, gr_we, use1, use2;
      logic [31:0] target, rj, rkd;
      logic [4:0]  dest, ra1, ra2;
   } exp_t;

   // Reference model: instruction kinds and hazard rules straight from the
   // ISA description, with stages scanned youngest-first.
   function automatic exp_t model_eval();
      exp_t e;
      logic [5:0]  op;
      logic [9:0]  hi10;
      logic [6:0]  hi7;
      logic        kb, kbl, kj, kc, ks, stall, ct, ready;
      logic [4:0]  src [2];
      logic        used [2];
      logic [31:0] val [2];
      logic        sv [3], sw [3];
      logic [4:0]  sd [3];
      logic [31:0] sf [3];
      logic [25:0] t26;
      int          o16, o26;
      op = m_inst[31:26]; hi10 = m_inst[31:22]; hi7 = m_inst[31:25];
      kj = (op == 6'h13); kb = (op == 6'h14); kbl = (op == 6'h15);
      kc = (op >= 6'h16) && (op <= 6'h1b);
      ks = (hi10 == 10'h0a4) || (hi10 == 10'h0a5) || (hi10 == 10'h0a6);
      e.ra1 = m_inst[9:5];
      e.ra2 = (kc || ks) ? m_inst[4:0] : m_inst[14:10];
      e.use1 = !(kb || kbl || hi7 == 7'h0a || hi7 == 7'h0e);
      e.use2 = (hi10 == 10'd0) || kc || ks;
      src[0] = e.ra1; src[1] = e.ra2; used[0] = e.use1; used[1] = e.use2;
      sv[0] = EX_valid; sv[1] = MEM_valid; sv[2] = WB_valid;
      sw[0] = EX_gr_we; sw[1] = MEM_gr_we; sw[2] = WB_gr_we;
      sd[0] = EX_dest;  sd[1] = MEM_dest;  sd[2] = WB_dest;
      sf[0] = EX_fwd;   sf[1] = MEM_fwd;   sf[2] = WB_fwd;
      stall = 1'b0;
      for (int s = 0; s < 2; s++) begin
         val[s] = rf[src[s]];
         if (src[s] != 0) begin
            for (int i = 0; i < 3; i++) begin
               if (sv[i] && sw[i] && sd[i] == src[s]) begin
`ifdef FORWARD_EN
                  val[s] = sf[i];
                  if (i == 0 && EX_is_load && used[s]) stall = 1'b1;
`else
                  if (used[s]) stall = 1'b1;
`endif
                  break;
               end
            end
         end
      end
      e.rj = val[0]; e.rkd = val[1];
      ready = !stall;
      case (op)
         6'h16: ct = (e.rj == e.rkd);
         6'h17: ct = (e.rj != e.rkd);
         6'h18: ct = ($signed(e.rj) <  $signed(e.rkd));
         6'h19: ct = ($signed(e.rj) >= $signed(e.rkd));
         6'h1a: ct = (e.rj <  e.rkd);
         6'h1b: ct = (e.rj >= e.rkd);
         default: ct = 1'b0;
      endcase
      e.allowin = !m_valid || (ready && EX_allowin);
      e.to_ex   = m_valid && ready;
      e.taken   = m_valid && ready && EX_allowin && (kb || kbl || kj || ct);
      o16 = int'($signed(m_inst[25:10]));
      t26 = {m_inst[9:0], m_inst[25:10]};
      o26 = int'($signed(t26));
      if (kj)             e.target = e.rj + 32'(o16 * 4);
      else if (kb || kbl) e.target = m_pc + 32'(o26 * 4);
      else                e.target = m_pc + 32'(o16 * 4);
      e.dest  = kbl ? 5'd1 : m_inst[4:0];
      e.gr_we = !(kb || kc || ks || e.dest == 5'd0);
      return e;
   endfunction

   task automatic clear_stages();
      EX_valid = 0; MEM_valid = 0; WB_valid = 0;
      EX_gr_we = 0; MEM_gr_we = 0; WB_gr_we = 0;
      EX_dest = 0; MEM_dest = 0; WB_dest = 0; EX_is_load = 0;
      EX_fwd = 32'hE0E0E0E0; MEM_fwd = 32'hB0B0B0B0; WB_fwd = 32'hC0C0C0C0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; IF_to_ID_valid = 0; EX_allowin = 1; clear_stages();
      @(negedge clk);
      reset = 0;
      m_valid = 0; m_pc = RESET_PC; m_inst = 0;
   endtask

   // offer one instruction at a negedge; it is captured at the next posedge
   task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
      @(negedge clk);
      IF_to_ID_valid = 1; IF_pc_in = pc; IF_inst_in = inst;
      @(negedge clk);
      IF_to_ID_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (ID_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ID_allowin); end
      checks++; if (ID_to_EX_valid !== 1'b0) begin failures++; $display("FAIL reset_to_ex got=%b exp=0", ID_to_EX_valid); end
      checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
      checks++; if (ID_pc_out !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", ID_pc_out, RESET_PC); end
      checks++; if (ID_inst_out !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", ID_inst_out); end
   endtask

   task automatic test_beq_taken();
      do_reset();
      rf[4] = 32'h00001234;
      @(negedge clk);
      IF_to_ID_valid = 1; IF_pc_in = 32'h1c000010; IF_inst_in = {6'h16, 16'd4, 5'd4, 5'd4};
      @(negedge clk);
      IF_pc_in = 32'h1c000014; IF_inst_in = 32'h00101ca6;   // wrong-path add.w
      #1;
      checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", br_taken); end
      checks++; if (br_target !== 32'h1c000020) begin failures++; $display("FAIL beq_target got=%h exp=1c000020", br_target); end
      @(negedge clk);
      IF_to_ID_valid = 0;
      #1;
      checks++; if (ID_to_EX_valid !== 1'b0) begin failures++; $display("FAIL beq_drop_slot got=%b exp=0", ID_to_EX_valid); end
      checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL beq_once got=%b exp=0", br_taken); end
   endtask

   task automatic test_raw_alu();
      logic exp_go;
      do_reset();
      rf[5] = 32'h00000055; rf[7] = 32'h00000007;
      EX_allowin = 0;
      EX_valid = 1; EX_gr_we = 1; EX_dest = 5;
      offer(32'h1c000100, 32'h00101ca6);    // add.w r6, r5, r7
      for (int ph = 0; ph < 4; ph++) begin
         clear_stages();
         if (ph == 0) begin EX_valid = 1;  EX_gr_we = 1;  EX_dest = 5;  end
         if (ph == 1) begin MEM_valid = 1; MEM_gr_we = 1; MEM_dest = 5; end
         if (ph == 2) begin WB_valid = 1;  WB_gr_we = 1;  WB_dest = 5;  end
         #1;
`ifdef FORWARD_EN
         exp_go = 1'b1;
         checks++;
         if (ID_rj_value !== (ph == 0 ? EX_fwd : ph == 1 ? MEM_fwd : ph == 2 ? WB_fwd : 32'h55)) begin
            failures++; $display("FAIL raw_fwd_value ph=%0d got=%h", ph, ID_rj_value);
         end
`else
         exp_go = (ph == 3);
`endif
         checks++; if (ID_to_EX_valid !== exp_go) begin failures++; $display("FAIL raw_ready ph=%0d got=%b exp=%b", ph, ID_to_EX_valid, exp_go); end
         if (ph == 3) begin
            checks++; if (ID_rj_value !== 32'h55) begin failures++; $display("FAIL raw_rf_value got=%h exp=00000055", ID_rj_value); end
         end
         @(negedge clk);
      end
      EX_allowin = 1;
      @(negedge clk);
   endtask

   task automatic test_load_use();
      do_reset();
      rf[5] = 32'h00000055;
      EX_valid = 1; EX_gr_we = 1; EX_dest = 5; EX_is_load = 1;
      offer(32'h1c000200, 32'h00101ca6);
      #1;
      checks++; if (ID_to_EX_valid !== 1'b0) begin failures++; $display("FAIL load_stall got=%b exp=0", ID_to_EX_valid); end
      @(negedge clk);
      clear_stages(); MEM_valid = 1; MEM_gr_we = 1; MEM_dest = 5; MEM_fwd = 32'h00001234;
      #1;
`ifdef FORWARD_EN
      checks++; if (ID_to_EX_valid !== 1'b1) begin failures++; $display("FAIL load_release got=%b exp=1", ID_to_EX_valid); end
      checks++; if (ID_rj_value !== 32'h1234) begin failures++; $display("FAIL load_mem_fwd got=%h exp=00001234", ID_rj_value); end
`else
      checks++; if (ID_to_EX_valid !== 1'b0) begin failures++; $display("FAIL load_mem_stall got=%b exp=0", ID_to_EX_valid); end
`endif
      clear_stages();
      @(negedge clk);
   endtask

   task automatic test_b_hold();
      do_reset();
      EX_allowin = 0;
      offer(32'h1c000000, 32'h53ffffff);    // b offs26 = -1
      #1;
      checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL b_hold_taken got=%b exp=0", br_taken); end
      checks++; if (ID_allowin !== 1'b0) begin failures++; $display("FAIL b_hold_allowin got=%b exp=0", ID_allowin); end
      @(negedge clk);
      #1;
      checks++; if (ID_pc_out !== 32'h1c000000) begin failures++; $display("FAIL b_hold_pc got=%h exp=1c000000", ID_pc_out); end
      EX_allowin = 1;
      #1;
      checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL b_release_taken got=%b exp=1", br_taken); end
      checks++; if (br_target !== 32'h1bfffffc) begin failures++; $display("FAIL b_target got=%h exp=1bfffffc", br_target); end
      @(negedge clk);
      #1;
      checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL b_once got=%b exp=0", br_taken); end
   endtask

   task automatic test_r0_source();
      do_reset();
      EX_valid = 1; EX_gr_we = 1; EX_dest = 0;
      offer(32'h1c000300, 32'h00101c06);    // add.w r6, r0, r7
      #1;
      checks++; if (ID_to_EX_valid !== 1'b1) begin failures++; $display("FAIL r0_no_stall got=%b exp=1", ID_to_EX_valid); end
      checks++; if (ID_rj_value !== 32'd0) begin failures++; $display("FAIL r0_value got=%h exp=0", ID_rj_value); end
      clear_stages();
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      EX_allowin = 1;
      EX_valid = 1; EX_gr_we = 1; EX_dest = 5; EX_is_load = 1;
      offer(32'h1c000400, 32'h00101ca6);
      #1;
      checks++; if (ID_allowin !== 1'b0) begin failures++; $display("FAIL stall_before_reset got=%b exp=0", ID_allowin); end
      #1 reset = 1;
      #1;
      checks++; if (ID_allowin !== 1'b1) begin failures++; $display("FAIL async_reset_allowin got=%b exp=1", ID_allowin); end
      checks++; if (ID_pc_out !== RESET_PC) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", ID_pc_out, RESET_PC); end
      checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL async_reset_taken got=%b exp=0", br_taken); end
      @(negedge clk);
      reset = 0; clear_stages();
   endtask

   task automatic test_random();
      exp_t e;
      logic [31:0] w;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         for (int r = 1; r < 32; r++) begin
            case ($urandom_range(0, 4))
               0: rf[r] = 32'd1;
               1: rf[r] = 32'hffffffff;
               2: rf[r] = 32'h80000000;
               3: rf[r] = 32'h7fffffff;
               default: rf[r] = $urandom;
            endcase
         end
         w = $urandom;
         w[4:0] = 5'($urandom_range(0, 7)); w[9:5] = 5'($urandom_range(0, 7));
         w[14:10] = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 11))
            0: w[31:26] = 6'h13;
            1: w[31:26] = 6'h14;
            2: w[31:26] = 6'h15;
            3, 4, 5, 6, 7, 8: w[31:26] = 6'(6'h16 + 6'($urandom_range(0, 5)));
            9: w[31:22] = 10'(10'h0a4 + 10'($urandom_range(0, 2)));
            10: w[31:15] = 17'h00020;
            default: w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h0a : 7'h0e;
         endcase
         IF_to_ID_valid = ($urandom_range(0, 9) < 7);
         IF_pc_in = {$urandom} & 32'hfffffffc; IF_inst_in = w;
         EX_allowin = ($urandom_range(0, 3) != 0);
         EX_valid = $urandom_range(0, 1); MEM_valid = $urandom_range(0, 1); WB_valid = $urandom_range(0, 1);
         EX_gr_we = $urandom_range(0, 1); MEM_gr_we = $urandom_range(0, 1); WB_gr_we = $urandom_range(0, 1);
         EX_dest = 5'($urandom_range(0, 7)); MEM_dest = 5'($urandom_range(0, 7)); WB_dest = 5'($urandom_range(0, 7));
         EX_is_load = ($urandom_range(0, 2) == 0);
         EX_fwd = $urandom; MEM_fwd = $urandom; WB_fwd = $urandom;
         #1;
         e = model_eval();
         checks++; if (ID_allowin !== e.allowin) begin failures++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, ID_allowin, e.allowin); end
         checks++; if (ID_to_EX_valid !== e.to_ex) begin failures++; $display("FAIL rnd_to_ex cyc=%0d got=%b exp=%b", cyc, ID_to_EX_valid, e.to_ex); end
         checks++; if (br_taken !== e.taken) begin failures++; $display("FAIL rnd_taken cyc=%0d got=%b exp=%b", cyc, br_taken, e.taken); end
         checks++; if (ID_pc_out !== m_pc || ID_inst_out !== m_inst) begin failures++; $display("FAIL rnd_latch cyc=%0d got=%h/%h exp=%h/%h", cyc, ID_pc_out, ID_inst_out, m_pc, m_inst); end
         checks++; if (rf_raddr1 !== e.ra1 || rf_raddr2 !== e.ra2) begin failures++; $display("FAIL rnd_raddr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, rf_raddr1, rf_raddr2, e.ra1, e.ra2); end
         if (m_valid) begin
            checks++; if (ID_dest !== e.dest || ID_gr_we !== e.gr_we) begin failures++; $display("FAIL rnd_dest cyc=%0d got=%0d/%b exp=%0d/%b", cyc, ID_dest, ID_gr_we, e.dest, e.gr_we); end
            if (e.use1) begin
               checks++; if (ID_rj_value !== e.rj) begin failures++; $display("FAIL rnd_rj cyc=%0d got=%h exp=%h", cyc, ID_rj_value, e.rj); end
            end
            if (e.use2) begin
               checks++; if (ID_rkd_value !== e.rkd) begin failures++; $display("FAIL rnd_rkd cyc=%0d got=%h exp=%h", cyc, ID_rkd_value, e.rkd); end
            end
            if (e.taken) begin
               checks++; if (br_target !== e.target) begin failures++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, br_target, e.target); end
            end
         end
         if (e.allowin) m_valid = IF_to_ID_valid && !e.taken;
         if (e.allowin && IF_to_ID_valid) begin m_pc = IF_pc_in; m_inst = IF_inst_in; end
      end
      @(negedge clk);
      IF_to_ID_valid = 0;
   endtask

   initial begin
      reset = 1; IF_to_ID_valid = 0; IF_pc_in = 0; IF_inst_in = 0; EX_allowin = 1;
      clear_stages();
      for (int r = 0; r < 32; r++) rf[r] = 32'(r * 16);
      rf[0] = 32'd0;
      m_valid = 0; m_pc = RESET_PC; m_inst = 0;
      test_reset();
      test_beq_taken();
      test_raw_alu();
      test_load_use();
      test_b_hold();
      test_r0_source();
      test_random();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_stream.md
Name: id_stream

Overview:
- Decode/operand-fetch stage, directly downstream of the fetch stage.
- Latches {pc, inst} via valid/allowin handshake and reads the register file; resolves RAW hazards by stall (optionally forwarding).
- Resolves all LA32R branches/jumps in ID and returns br_taken/br_target to fetch; forwards pc, inst, operands and destination info to EX.
- Full ALU/mem decode is done in EX.

Parameters:
RESET_PC, 32'h1bfffffc, ID_pc reset value (matches fetch reset trick)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
IF_to_ID_valid  in  1  fetch offers an instruction
IF_pc_in  in  32  pc of offered instruction
IF_inst_in  in  32  offered instruction
ID_allowin  out  1  ID can accept this cycle
EX_allowin  in  1  EX can accept this cycle
ID_to_EX_valid  out  1  ID hands an instruction to EX
ID_pc_out  out  32  latched pc
ID_inst_out  out  32  latched inst
ID_rj_value  out  32  source-1 operand
ID_rkd_value  out  32  source-2 operand (rk or rd)
ID_dest  out  5  destination register
ID_gr_we  out  1  instruction writes GPR
br_taken  out  1  redirect fetch (single-cycle pulse)
br_target  out  32  redirect address
rf_raddr1  out  5  regfile read port 1 (= inst[9:5])
rf_raddr2  out  5  regfile read port 2
rf_rdata1  in  32  regfile data 1 (combinational)
rf_rdata2  in  32  regfile data 2
EX_valid, MEM_valid, WB_valid  in  1 each  stage holds live inst
EX_gr_we, MEM_gr_we, WB_gr_we  in  1 each  stage writes GPR
EX_dest, MEM_dest, WB_dest  in  5 each  stage destination
EX_is_load  in  1  EX instruction is a load
EX_fwd, MEM_fwd, WB_fwd  in  32 each  result data per stage (used only with forwarding)

Behaviour:
- Reset (async): ID_valid=0, ID_pc=RESET_PC, ID_inst=0. Hence ID_to_EX_valid=0, br_taken=0, ID_allowin=1.
- ID_allowin = !ID_valid || (ID_ready_go && EX_allowin). ID_to_EX_valid = ID_valid && ID_ready_go.
- Capture: on clk when ID_allowin, ID_valid <= IF_to_ID_valid && !br_taken. pc/inst load only when IF_to_ID_valid && ID_allowin.
  - When the branch leaves with br_taken=1, the sequential instruction offered that same cycle is discarded (wrong path).
- Decode on inst[31:26]: jirl 010011, b 010100, bl 010101, beq 010110, bne 010111, blt 011000, bge 011001, bltu 011010, bgeu 011011.
- rf_raddr2 = inst[4:0] if conditional branch or store (inst[31:22] in 0010100100/0101/0110); otherwise inst[14:10].
- Source use:
  - rj used unless b, bl, lu12i.w or pcaddu12i (inst[31:25] = 0001010 / 0001110).
  - raddr2 used if inst[31:22]==0, conditional branch, or store.
  - Reg 0 never hazards.
- ID_dest = bl ? 5'd1 : inst[4:0]. ID_gr_we = 0 for b, conditional branches, stores, or dest==0; else 1.
- Hazard without forwarding: ID_ready_go=0 while any used source matches a valid stage's dest with gr_we=1 (EX, MEM or WB).
- br_taken = ID_valid && ID_ready_go && EX_allowin && (b | bl | jirl | condition true).
  - Conditions: eq/ne on equality; lt/ge signed; ltu/geu unsigned; comparing rj vs rkd.
- br_target:
  - jirl: rj + sext(inst[25:10],2'b0).
  - b/bl: pc + sext({inst[9:0],inst[25:10]},2'b0).
  - Conditional branches: pc + sext(inst[25:10],2'b0).
  - All 32-bit, wrap-around.
- bl/jirl link value (pc+4) is computed in EX, not here.
- Stalled ID holds pc/inst and deasserts br_taken; a branch fires only once.

Optional Feature:
FORWARD_EN
- Defined: operands select EX_fwd > MEM_fwd > WB_fwd > rf_rdata on dest match (youngest wins). Only EX_is_load with a match stalls; stall is one cycle unless EX itself stalls.
- Undefined: forwarding inputs are ignored and the stall rule above applies.

Test Plan:
- Reset mid-stall with ID_valid=1 -> next edge ID_valid=0, ID_pc=0x1bfffffc, br_taken=0 immediately (async).
- beq r4,r4,offs16=4 at pc 0x1c000010, EX_allowin=1 -> br_taken=1 for one cycle, target 0x1c000020; instruction 0x1c000014 offered same cycle is dropped (ID_valid=0).
- add.w r5,.. in EX (gr_we=1), ID add.w r6,r5,r7 -> no FORWARD_EN: ready_go=0 until WB leaves, operand = rf value; FORWARD_EN: zero stall, ID_rj_value = EX_fwd.
- ld.w r5 in EX (EX_is_load=1), ID uses r5, FORWARD_EN -> one stall cycle, then MEM_fwd used.
- EX_allowin=0 with taken b at pc 0x1c000000 offs26=-1 -> br_taken stays 0, ID holds; when EX_allowin=1 -> br_target 0x1bfffffc.
- Source r0 matching EX_dest=0 with gr_we=1 -> no stall, operand 0.
